// File: rtl/ysyx_23060208_ifu_prefetch_if.sv
// IFU-side bundle: EXU redirect, IDU delivery handshake and AXI4-Lite instruction read channel.
// master = IFU, slave = the IDU/EXU/SRAM environment.
interface ysyx_23060208_ifu_prefetch_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned BUS_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  ifu_to_idu_valid;
  logic                  idu_ready;
  logic [BUS_WIDTH-1:0]  ifu_to_idu_bus;
  logic [ADDR_WIDTH-1:0] isram_araddr;
  logic                  isram_arvalid;
  logic                  isram_arready;
  logic [DATA_WIDTH-1:0] isram_rdata;
  logic [1:0]            isram_rresp;
  logic                  isram_rvalid;
  logic                  isram_rready;
  logic [ADDR_WIDTH-1:0] fetch_pc;

  modport master (
    input  redirect_valid, redirect_pc, idu_ready,
           isram_arready, isram_rdata, isram_rresp, isram_rvalid,
    output ifu_to_idu_valid, ifu_to_idu_bus, isram_araddr, isram_arvalid,
           isram_rready, fetch_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, idu_ready,
           isram_arready, isram_rdata, isram_rresp, isram_rvalid,
    input  ifu_to_idu_valid, ifu_to_idu_bus, isram_araddr, isram_arvalid,
           isram_rready, fetch_pc
  );
endinterface

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Prefetching instruction-fetch unit: one outstanding AXI4-Lite read feeding a FIFO_DEPTH-entry
// buffer of {pc, inst, fault}; EXU redirects flush the buffer and discard the in-flight response.
module ysyx_23060208_ifu_prefetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_23060208_ifu_prefetch_if.master  bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = ADDR_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_req_pc, w_req_pc_nxt;
  logic                  r_drop, w_drop_nxt;
  logic [BW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_valid, r_arvalid, r_rready;
  logic                  w_push, w_pop, w_flush;

  // Next-state: a slot is reserved when the read is requested, so a push never overflows.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = bus.redirect_valid ? bus.redirect_pc : r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    w_flush        = bus.redirect_valid;
    w_pop          = r_valid && bus.idu_ready;
    w_push         = (r_state == S_DATA) && bus.isram_rvalid && !r_drop && !w_flush;
    w_count_nxt    = w_flush ? '0 : CW'(r_count + CW'(w_push) - CW'(w_pop));
    case (r_state)
      S_IDLE: begin
        if (w_flush || (r_count < CW'(FIFO_DEPTH))) begin
          w_state_nxt  = S_ADDR;
          w_req_pc_nxt = w_fetch_pc_nxt;
        end
      end
      S_ADDR: begin
        if (bus.isram_arready) begin
          w_state_nxt = S_DATA;
          // A redirect during this request already pointed fetch_pc at the target.
          if (!r_drop && !w_flush) begin
            w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);
          end
        end
      end
      S_DATA: begin
        if (bus.isram_rvalid) begin
          w_drop_nxt = 1'b0;
          if (w_count_nxt < CW'(FIFO_DEPTH)) begin
            w_state_nxt  = S_ADDR;
            w_req_pc_nxt = w_fetch_pc_nxt;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Only a read still outstanding after this cycle needs its response discarded.
    if (w_flush && ((r_state == S_ADDR) || ((r_state == S_DATA) && !bus.isram_rvalid))) begin
      w_drop_nxt = 1'b1;
    end
  end

  // State, control and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_count    <= w_count_nxt;
      r_valid    <= (w_count_nxt != '0);
      r_arvalid  <= (w_state_nxt == S_ADDR);
      r_rready   <= (w_state_nxt == S_DATA);
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= {r_req_pc, bus.isram_rdata, (bus.isram_rresp != 2'b00)};
          r_wptr        <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
      end
    end
  end

  assign bus.ifu_to_idu_valid = r_valid;
  assign bus.ifu_to_idu_bus   = r_mem[r_rptr];
  assign bus.isram_araddr     = r_req_pc;
  assign bus.isram_arvalid    = r_arvalid;
  assign bus.isram_rready     = r_rready;
  assign bus.fetch_pc         = r_fetch_pc;
endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Bench for the prefetching IFU: AXI4-Lite SRAM model with programmable latency, program-order
// scoreboard of {pc, inst, fault}, directed timing scenarios and a randomized redirect/backpressure run.
module tb_ysyx_23060208_ifu_prefetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060208_ifu_prefetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifc ();

  ysyx_23060208_ifu_prefetch #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ent_t        exp_q[$];
  ent_t        pend_q[$];
  bit          flush_pend = 1'b0;
  logic [31:0] gen_pc;
  logic [31:0] ar_q[$];
  int unsigned ar_len_q[$];
  int unsigned ar_cnt = 0, ar_len = 0, dlv = 0, dlv_total = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;

  int unsigned cfg_ar = 0, cfg_r = 1;
  bit          cfg_rand = 1'b0;
  int unsigned pre_ar, pre_r;

  // Memory contents and error responses as pure functions of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9bdf;
  endfunction
  function automatic logic fault_of(input logic [31:0] pc);
    return (pc == 32'h8000_0008) || (pc[6:2] == 5'd19);
  endfunction
  function automatic logic [1:0] resp_of(input logic [31:0] pc);
    return fault_of(pc) ? (pc[9] ? 2'b11 : 2'b10) : 2'b00;
  endfunction
  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc = pc; e.inst = inst_of(pc); e.fault = fault_of(pc);
    return e;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The program-order stream restarts at pc; takes effect after this cycle's delivery check.
  task automatic load_pend(input logic [31:0] pc);
    pend_q.delete();
    for (int i = 0; i < 32; i++) pend_q.push_back(mk(pc + 32'(4 * i)));
    gen_pc = pc + 32'd128;
    flush_pend = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!flush_pend && exp_q.size() < 16) begin
      for (int i = 0; i < 32; i++) begin
        exp_q.push_back(mk(gen_pc));
        gen_pc = gen_pc + 32'd4;
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = pc;
    load_pend(pc);
  endtask

  // Reset IFU and SRAM together; returns in cycle 0 (first cycle with rst low).
  task automatic do_reset(input int unsigned ar_d, input int unsigned r_d, input bit rnd, input bit rdy);
    rst = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.idu_ready      = rdy;
    cfg_ar = ar_d; cfg_r = r_d; cfg_rand = rnd;
    load_pend(RESET_PC);
    tick();
    tick();
    @(negedge clk);
    chk("rst_arvalid", 65'(ifc.isram_arvalid), 65'(0));
    chk("rst_rready", 65'(ifc.isram_rready), 65'(0));
    chk("rst_valid", 65'(ifc.ifu_to_idu_valid), 65'(0));
    chk("rst_fetch_pc", 65'(ifc.fetch_pc), 65'(RESET_PC));
    chk("rst_araddr", 65'(ifc.isram_araddr), 65'(RESET_PC));
    chk("rst_bus", 65'(ifc.ifu_to_idu_bus), 65'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    ar_q.delete();
    ar_len_q.delete();
    ar_cnt = 0;
    dlv = 0;
  endtask

  // Latencies for the next transaction, drawn away from the active edge.
  always @(negedge clk) begin
    pre_ar <= cfg_rand ? $urandom_range(0, 3) : cfg_ar;
    pre_r  <= cfg_rand ? $urandom_range(1, 4) : cfg_r;
  end

  // AXI4-Lite instruction SRAM: arready after ar_d stalled cycles, rvalid r_d cycles after AR.
  int unsigned sr_ar_d, sr_cnt, sr_rcnt;
  logic        sr_busy;
  logic [31:0] sr_addr;
  always @(posedge clk) begin
    if (rst) begin
      sr_busy            <= 1'b0;
      sr_cnt             <= 0;
      sr_rcnt            <= 0;
      sr_ar_d            <= cfg_ar;
      sr_addr            <= 32'h0;
      ifc.isram_arready  <= (!cfg_rand && cfg_ar == 0);
      ifc.isram_rvalid   <= 1'b0;
      ifc.isram_rdata    <= 32'h0;
      ifc.isram_rresp    <= 2'b00;
    end else begin
      if (ifc.isram_rvalid && ifc.isram_rready) ifc.isram_rvalid <= 1'b0;
      if (ifc.isram_arvalid && ifc.isram_arready) begin
        sr_ar_d           <= pre_ar;
        sr_cnt            <= 0;
        ifc.isram_arready <= (pre_ar == 0);
        if (pre_r <= 1) begin
          ifc.isram_rvalid <= 1'b1;
          ifc.isram_rdata  <= inst_of(ifc.isram_araddr);
          ifc.isram_rresp  <= resp_of(ifc.isram_araddr);
        end else begin
          sr_busy <= 1'b1;
          sr_rcnt <= pre_r - 1;
          sr_addr <= ifc.isram_araddr;
        end
      end else if (ifc.isram_arvalid) begin
        sr_cnt            <= sr_cnt + 1;
        ifc.isram_arready <= (sr_cnt + 1 >= sr_ar_d);
      end
      if (sr_busy) begin
        if (sr_rcnt == 1) begin
          ifc.isram_rvalid <= 1'b1;
          ifc.isram_rdata  <= inst_of(sr_addr);
          ifc.isram_rresp  <= resp_of(sr_addr);
          sr_busy          <= 1'b0;
        end else begin
          sr_rcnt <= sr_rcnt - 1;
        end
      end
    end
  end

  // Monitor: scoreboard pops on each accepted entry; AR stability and handshake log.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.ifu_to_idu_valid && ifc.idu_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 65'(ifc.ifu_to_idu_bus), 65'(0));
        end else begin
          chk("deliver", 65'(ifc.ifu_to_idu_bus), 65'(exp_q.pop_front()));
        end
        dlv++;
        dlv_total++;
      end
      if (prev_stall) begin
        chk("ar_hold_valid", 65'(ifc.isram_arvalid), 65'(1));
        chk("ar_hold_addr", 65'(ifc.isram_araddr), 65'(prev_addr));
      end
      prev_stall = ifc.isram_arvalid && !ifc.isram_arready;
      prev_addr  = ifc.isram_araddr;
      if (ifc.isram_arvalid) ar_len++;
      if (ifc.isram_arvalid && ifc.isram_arready) begin
        ar_q.push_back(ifc.isram_araddr);
        ar_len_q.push_back(ar_len);
        ar_len = 0;
        ar_cnt++;
      end
    end else begin
      prev_stall = 1'b0;
      ar_len     = 0;
    end
    if (flush_pend) begin
      exp_q = pend_q;
      flush_pend = 1'b0;
    end
  end

  initial begin
    int unsigned d0;
    rst = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.idu_ready      = 1'b1;

    // Zero-wait SRAM, IDU always ready: latency, fault tagging, throughput, AR sequence.
    do_reset(0, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("c0_arvalid", 65'(ifc.isram_arvalid), 65'(0));
    tick(); @(negedge clk);
    chk("c1_arvalid", 65'(ifc.isram_arvalid), 65'(1));
    chk("c1_araddr", 65'(ifc.isram_araddr), 65'(RESET_PC));
    tick(); @(negedge clk);
    chk("c2_valid", 65'(ifc.ifu_to_idu_valid), 65'(0));
    chk("c2_rready", 65'(ifc.isram_rready), 65'(1));
    tick(); @(negedge clk);
    chk("c3_valid", 65'(ifc.ifu_to_idu_valid), 65'(1));
    repeat (4) tick();
    @(negedge clk);
    chk("c7_pc", 65'(ifc.ifu_to_idu_bus[64:33]), 65'(32'h8000_0008));
    chk("c7_fault", 65'(ifc.ifu_to_idu_bus[0]), 65'(1));
    repeat (2) tick();
    @(negedge clk);
    chk("c9_pc", 65'(ifc.ifu_to_idu_bus[64:33]), 65'(32'h8000_000C));
    chk("c9_fault", 65'(ifc.ifu_to_idu_bus[0]), 65'(0));
    repeat (9) tick();
    chk("throughput", 65'(dlv), 65'(8));
    chk("ar_seq_len", 65'(ar_q.size() >= 8), 65'(1));
    for (int k = 0; k < 8; k++) begin
      if (ar_q.size() > 0) chk("ar_seq", 65'(ar_q.pop_front()), 65'(RESET_PC + 32'(4 * k)));
    end

    // IDU stalled: exactly FIFO_DEPTH reads, then drain with no loss or duplication.
    do_reset(0, 1, 1'b0, 1'b0);
    repeat (30) tick();
    chk("full_ar_cnt", 65'(ar_cnt), 65'(4));
    chk("full_arvalid", 65'(ifc.isram_arvalid), 65'(0));
    chk("full_valid", 65'(ifc.ifu_to_idu_valid), 65'(1));
    ifc.idu_ready = 1'b1;
    repeat (40) tick();
    chk("drain_progress", 65'(dlv >= 12), 65'(1));

    // arready delayed three cycles: four-cycle AR with a single handshake.
    do_reset(3, 1, 1'b0, 1'b1);
    repeat (12) tick();
    chk("slow_ar_seen", 65'(ar_len_q.size() >= 2), 65'(1));
    if (ar_len_q.size() >= 2) begin
      chk("slow_ar_len0", 65'(ar_len_q[0]), 65'(4));
      chk("slow_ar_len1", 65'(ar_len_q[1]), 65'(4));
      chk("slow_ar_addr1", 65'(ar_q[1]), 65'(RESET_PC + 32'd4));
    end

    // Redirect while waiting for data; the stale response arrives two cycles later.
    do_reset(0, 3, 1'b0, 1'b1);
    tick();
    tick();
    redirect_to(32'h8000_0100);
    tick();
    ifc.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_empty", 65'(ifc.ifu_to_idu_valid), 65'(0));
    tick();
    tick();
    @(negedge clk);
    chk("redir_arvalid", 65'(ifc.isram_arvalid), 65'(1));
    chk("redir_araddr", 65'(ifc.isram_araddr), 65'(32'h8000_0100));
    repeat (20) tick();
    chk("redir_delivers", 65'(dlv >= 2), 65'(1));

    // Redirect coinciding with rvalid and a pop.
    do_reset(0, 1, 1'b0, 1'b0);
    repeat (4) tick();
    d0 = dlv;
    ifc.idu_ready = 1'b1;
    redirect_to(32'h8000_0200);
    tick();
    ifc.redirect_valid = 1'b0;
    @(negedge clk);
    chk("coin_pop_taken", 65'(dlv - d0), 65'(1));
    chk("coin_empty", 65'(ifc.ifu_to_idu_valid), 65'(0));
    chk("coin_fetch_pc", 65'(ifc.fetch_pc), 65'(32'h8000_0200));
    chk("coin_araddr", 65'(ifc.isram_araddr), 65'(32'h8000_0200));
    chk("coin_arvalid", 65'(ifc.isram_arvalid), 65'(1));
    repeat (20) tick();

    // Randomized latency, backpressure, redirects and occasional reset.
    do_reset(0, 1, 1'b1, 1'b1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset(0, 1, 1'b1, 1'b1);
      ifc.idu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) redirect_to(32'h8000_0000 | 32'($urandom_range(0, 1023) << 2));
      else ifc.redirect_valid = 1'b0;
      tick();
    end
    ifc.redirect_valid = 1'b0;
    ifc.idu_ready = 1'b1;
    repeat (30) tick();
    chk("overall_progress", 65'(dlv_total > 500), 65'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
